// File: rtl/rs_src_arbiter.sv
// Arbitrates NUM_CH source-address requesters (round-robin or fixed priority, optional
// multi-beat lock) onto one registered rs_addr/rs_owner valid/ready port for the regfile.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

module rs_src_arbiter #(
    parameter int NUM_CH      = 3,
    parameter int ADDR_WIDTH  = `ADDR_WIDTH,
    parameter bit RR_MODE     = 1'b1,
    localparam int OWN_W      = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            req_valid,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CH-1:0]            req_lock,
    output logic [NUM_CH-1:0]            req_ready,
    output logic                         rs_valid,
    output logic [ADDR_WIDTH-1:0]        rs_addr,
    output logic [OWN_W-1:0]             rs_owner,
    input  logic                         rs_ready,
    output logic                         locked
);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t             r_state;
    lock_state_t             w_state_nxt;
    logic                    r_rs_valid;
    logic [ADDR_WIDTH-1:0]   r_rs_addr;
    logic [OWN_W-1:0]        r_rs_owner;
    logic [OWN_W-1:0]        r_lock_owner;
    logic [OWN_W-1:0]        w_lock_owner_nxt;
    logic [OWN_W-1:0]        r_rr_ptr;
    logic [OWN_W-1:0]        w_rr_ptr_nxt;
    logic [OWN_W-1:0]        w_sel;
    logic [OWN_W-1:0]        w_cand;
    logic [NUM_CH-1:0]       w_elig;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic                    w_found;
    logic                    w_can_load;
    logic                    w_grant;

    // Explicit wrap against NUM_CH so non-power-of-two channel counts rotate correctly.
    function automatic logic [OWN_W-1:0] wrap_add(input logic [OWN_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_CH) s = s - NUM_CH;
        return s[OWN_W-1:0];
    endfunction

    always_comb begin
        w_elig = req_valid;
        if (r_state == ST_LOCKED) begin
            w_elig               = '0;
            w_elig[r_lock_owner] = req_valid[r_lock_owner];
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_cand = RR_MODE ? wrap_add(r_rr_ptr, k) : k[OWN_W-1:0];
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_can_load = !r_rs_valid || rs_ready;
    assign w_grant    = rst_n && w_can_load && w_found;
    assign req_ready  = w_grant ? (NUM_CH'(1) << w_sel) : '0;
    assign w_sel_addr = req_addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
        w_state_nxt      = r_state;
        w_lock_owner_nxt = r_lock_owner;
        w_rr_ptr_nxt     = r_rr_ptr;
        if (w_grant) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (req_lock[w_sel]) begin
                        w_state_nxt      = ST_LOCKED;
                        w_lock_owner_nxt = w_sel;
                    end
                end
                ST_LOCKED: begin
                    if (!req_lock[w_sel]) w_state_nxt = ST_UNLOCKED;
                end
                default: w_state_nxt = ST_UNLOCKED;
            endcase
            // The pointer is frozen for the whole locked burst, including its final beat.
            if (RR_MODE && (r_state == ST_UNLOCKED)) begin
                w_rr_ptr_nxt = (w_sel == OWN_W'(NUM_CH - 1)) ? '0 : w_sel + OWN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_UNLOCKED;
            r_lock_owner <= '0;
            r_rr_ptr     <= '0;
            r_rs_valid   <= 1'b0;
            r_rs_addr    <= '0;
            r_rs_owner   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_lock_owner <= w_lock_owner_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            if (w_grant) begin
                r_rs_valid <= 1'b1;
                r_rs_addr  <= w_sel_addr;
                r_rs_owner <= w_sel;
            end else if (w_can_load) begin
                r_rs_valid <= 1'b0;
            end
        end
    end

    assign rs_valid = r_rs_valid;
    assign rs_addr  = r_rs_addr;
    assign rs_owner = r_rs_owner;
    assign locked   = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_rs_src_arbiter.sv
// Directed bench for rs_src_arbiter: a round-robin and a fixed-priority instance,
// expected grants queued by the stimulus and consumed by per-instance monitors.
module tb_rs_src_arbiter;

    localparam int NCH = 3;
    localparam int AW  = 5;

    logic clk;
    logic rst_n;

    logic [NCH-1:0]    rr_valid, rr_lock, rr_req_ready;
    logic [NCH*AW-1:0] rr_addr;
    logic              rr_rs_valid, rr_rs_ready, rr_locked;
    logic [AW-1:0]     rr_rs_addr;
    logic [1:0]        rr_rs_owner;

    logic [NCH-1:0]    fp_valid, fp_lock, fp_req_ready;
    logic [NCH*AW-1:0] fp_addr;
    logic              fp_rs_valid, fp_rs_ready, fp_locked;
    logic [AW-1:0]     fp_rs_addr;
    logic [1:0]        fp_rs_owner;

    int n_vec;
    int n_err;
    logic [6:0] q_rr[$];
    logic [6:0] q_fp[$];

    rs_src_arbiter #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .RR_MODE(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_valid(rr_valid), .req_addr(rr_addr),
        .req_lock(rr_lock), .req_ready(rr_req_ready), .rs_valid(rr_rs_valid),
        .rs_addr(rr_rs_addr), .rs_owner(rr_rs_owner), .rs_ready(rr_rs_ready),
        .locked(rr_locked)
    );

    rs_src_arbiter #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .RR_MODE(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(fp_valid), .req_addr(fp_addr),
        .req_lock(fp_lock), .req_ready(fp_req_ready), .rs_valid(fp_rs_valid),
        .rs_addr(fp_rs_addr), .rs_owner(fp_rs_owner), .rs_ready(fp_rs_ready),
        .locked(fp_locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every completed output handshake must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n && rr_rs_valid && rr_rs_ready) begin
            if (q_rr.size() == 0) chk("rr_unexpected_beat", {rr_rs_owner, rr_rs_addr}, 32'hFFFF);
            else chk("rr_owner_addr", {rr_rs_owner, rr_rs_addr}, q_rr.pop_front());
        end
        if (rst_n && fp_rs_valid && fp_rs_ready) begin
            if (q_fp.size() == 0) chk("fp_unexpected_beat", {fp_rs_owner, fp_rs_addr}, 32'hFFFF);
            else chk("fp_owner_addr", {fp_rs_owner, fp_rs_addr}, q_fp.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        rr_addr = {5'd17, 5'd9, 5'd5};
        fp_addr = {5'd17, 5'd9, 5'd5};
        rr_valid = 3'b111;
        rr_lock = 3'b000;
        rr_rs_ready = 1'b1;
        fp_valid = 3'b000;
        fp_lock = 3'b000;
        fp_rs_ready = 1'b1;

        // Reset state, with requests already pending
        #12;
        chk("rst_rs_valid", rr_rs_valid, 0);
        chk("rst_req_ready", rr_req_ready, 0);
        chk("rst_locked", rr_locked, 0);
        chk("rst_rs_addr", rr_rs_addr, 0);

        // Round-robin fairness: owners 0,1,2,0,1,2
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            q_rr.push_back({2'(i % 3), (i % 3 == 0) ? 5'd5 : (i % 3 == 1) ? 5'd9 : 5'd17});
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_req_ready_pulse", rr_req_ready, 32'(1 << (i % 3)));
            step();
        end
        rr_valid = 3'b000;

        // Idle drain: single ch1 request, rs_valid high exactly one cycle
        step();
        rr_valid = 3'b010;
        q_rr.push_back({2'd1, 5'd9});
        step();
        rr_valid = 3'b000;
        @(negedge clk);
        chk("drain_valid_hi", rr_rs_valid, 1);
        step();
        @(negedge clk);
        chk("drain_valid_lo", rr_rs_valid, 0);
        chk("drain_addr_kept", rr_rs_addr, 9);
        step();

        // Backpressure: hold 4 cycles, then drain+load on same edge
        rr_rs_ready = 1'b0;
        rr_valid = 3'b001;
        q_rr.push_back({2'd0, 5'd5});
        step();
        rr_valid = 3'b011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid", rr_rs_valid, 1);
            chk("bp_owner_addr", {rr_rs_owner, rr_rs_addr}, {2'd0, 5'd5});
            chk("bp_req_ready", rr_req_ready, 0);
            step();
        end
        rr_rs_ready = 1'b1;
        q_rr.push_back({2'd1, 5'd9});
        @(negedge clk);
        chk("bp_release_ready", rr_req_ready, 3'b010);
        step();
        rr_valid = 3'b000;
        step();

        // Lock: ch2 three beats 3,4,6 while ch0/ch1 also request
        rr_valid = 3'b111;
        rr_lock = 3'b100;
        rr_addr = {5'd3, 5'd9, 5'd5};
        q_rr.push_back({2'd2, 5'd3});
        @(negedge clk);
        chk("lock_b1_ready", rr_req_ready, 3'b100);
        step();
        rr_addr = {5'd4, 5'd9, 5'd5};
        q_rr.push_back({2'd2, 5'd4});
        @(negedge clk);
        chk("lock_b1_locked", rr_locked, 1);
        chk("lock_b2_ready", rr_req_ready, 3'b100);
        step();
        rr_addr = {5'd6, 5'd9, 5'd5};
        rr_lock = 3'b000;
        q_rr.push_back({2'd2, 5'd6});
        @(negedge clk);
        chk("lock_b2_locked", rr_locked, 1);
        chk("lock_b3_ready", rr_req_ready, 3'b100);
        step();
        rr_valid = 3'b011;
        q_rr.push_back({2'd0, 5'd5});
        @(negedge clk);
        chk("unlock_locked", rr_locked, 0);
        chk("unlock_ready", rr_req_ready, 3'b001);
        step();
        rr_valid = 3'b000;
        step();

        // Async reset mid-transfer with a held output and an active lock
        rr_rs_ready = 1'b0;
        rr_valid = 3'b100;
        rr_lock = 3'b100;
        rr_addr = {5'd7, 5'd9, 5'd5};
        step();
        @(negedge clk);
        chk("pre_rst_valid", rr_rs_valid, 1);
        chk("pre_rst_locked", rr_locked, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", rr_rs_valid, 0);
        chk("async_rst_addr", rr_rs_addr, 0);
        chk("async_rst_owner", rr_rs_owner, 0);
        chk("async_rst_locked", rr_locked, 0);
        chk("async_rst_ready", rr_req_ready, 0);
        rr_valid = 3'b000;
        rr_lock = 3'b000;
        rr_rs_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        // Fixed priority: 110 -> ch1, ch1; then 111 -> ch0 repeatedly, ch2 never
        fp_valid = 3'b110;
        q_fp.push_back({2'd1, 5'd9});
        q_fp.push_back({2'd1, 5'd9});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("fp_ready_110", fp_req_ready, 3'b010);
            step();
        end
        fp_valid = 3'b111;
        for (int i = 0; i < 3; i++) q_fp.push_back({2'd0, 5'd5});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fp_ready_111", fp_req_ready, 3'b001);
            step();
        end
        fp_valid = 3'b000;
        step();
        step();

        chk("rr_queue_empty", q_rr.size(), 0);
        chk("fp_queue_empty", q_fp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rs_src_arbiter.md
Name: rs_src_arbiter

Overview:
Parametrised successor to the combinational rs1 source select. It takes up to NUM_CH controller channels (ADD, MULT, MULADD, and later units), each with a valid/ready request carrying a source-register address. It arbitrates among them (round-robin or fixed priority), optionally holds a lock for multi-beat owners, and presents one registered address with owner tag to the register-file read port over a valid/ready handshake. It sits between the unit controllers and the regfile rs read port and replaces the rs_sel-driven mux.

Parameters:
NUM_CH, 3, number of requesting channels; channel 0 = ADD, 1 = MULT, 2 = MULADD; legal range 2..8.
ADDR_WIDTH, `ADDR_WIDTH, register address width.
RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
OWN_W, $clog2(NUM_CH) (localparam), owner tag width.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NUM_CH  per-channel request valid.
req_addr  in  NUM_CH*ADDR_WIDTH  packed addresses; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
req_lock  in  NUM_CH  per-channel lock request, sampled on accept.
req_ready  out  NUM_CH  per-channel accept; combinational, at most one bit set.
rs_valid  out  1  output address valid (registered).
rs_addr  out  ADDR_WIDTH  granted source address (registered).
rs_owner  out  OWN_W  index of the granted channel (registered).
rs_ready  in  1  regfile port accepts rs_addr this cycle.
locked  out  1  a lock is currently held (registered).

Behaviour:
- Reset (rst_n = 0, async): rs_valid=0, rs_addr=0, rs_owner=0, locked=0, lock_owner=0, rr_ptr=0. req_ready is 0 while in reset.
- Slot free: can_load = !rs_valid || rs_ready.
- Eligible set:
  - locked=1: only req_valid[lock_owner] is eligible.
  - locked=0: all req_valid bits are eligible.
- Selection:
  - RR_MODE=1: first eligible index at or after rr_ptr, searching upward and wrapping from NUM_CH-1 to 0.
  - RR_MODE=0: lowest eligible index.
- Accept: when can_load and the eligible set is non-empty, set req_ready[sel]=1 (all other bits 0). On that edge:
  - rs_valid=1, rs_addr=req_addr[sel], rs_owner=sel.
  - In RR mode, rr_ptr = (sel+1) mod NUM_CH. rr_ptr does not move while locked.
- Latency: 1 cycle from request to rs_valid when the slot is free. Back-to-back accepts are allowed: full throughput 1/cycle while rs_ready=1.
- Output hold: while rs_valid=1 and rs_ready=0, rs_addr and rs_owner stay stable, and all req_ready bits are 0.
- No accept: if can_load and nothing is eligible, rs_valid goes to 0 on the edge; rs_addr and rs_owner keep their old values.
- Lock state machine (UNLOCKED / LOCKED):
  - UNLOCKED -> LOCKED: on an accept with req_lock[sel]=1; lock_owner=sel.
  - LOCKED -> LOCKED: on an accept from lock_owner with req_lock=1.
  - LOCKED -> UNLOCKED: on an accept from lock_owner with req_lock=0 (final beat).
  - While LOCKED, other channels are starved by design. The owner deasserting req_valid does not release the lock.
- Requester rule: a channel must hold req_valid and req_addr stable until it sees req_ready. The block does not check this.
- Simultaneous events: rs_ready=1 together with new eligible requests is handled as a same-edge drain plus load.
- Reset mid-transfer drops the pending output and any lock immediately. No grant is issued in the first cycle after reset release unless can_load holds (it does, since rs_valid=0).
- NUM_CH not a power of two: the rr_ptr wrap uses an explicit compare against NUM_CH-1, not a modulo on OWN_W bits.

Test Plan:
- Reset: assert rst_n=0 mid-stream with rs_valid=1 and locked=1 -> all outputs 0 asynchronously, before the next clk edge.
- Round-robin fairness: RR_MODE=1, req_valid=3'b111 constantly, addrs 5/9/17, rs_ready=1 -> rs_owner sequence 0,1,2,0,1,2 and rs_addr 5,9,17,5,... with one req_ready pulse per cycle.
- Fixed priority: RR_MODE=0, req_valid=3'b110 then 3'b111 -> owner 1,1, then 0 while ch0 stays valid; ch2 is never granted.
- Backpressure: rs_ready=0 for 4 cycles after an accept -> rs_addr/rs_owner constant, req_ready=0; when rs_ready=1, a new accept occurs on the same edge.
- Lock: ch2 sends 3 beats (req_lock=1,1,0, addrs 3,4,6) while ch0/ch1 are valid -> owners 2,2,2, locked=1 for beats 1-2, then ch0 is granted next and locked=0.
- Idle drain: single request then req_valid=0 with rs_ready=1 -> rs_valid is high for exactly 1 cycle and rs_addr keeps its last value.
